// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: frame-gated ball stepping, miss detection, scoring,
// serve hold and game-over handling.
module pong_game_ctrl #(
   parameter logic [9:0] LEFT_LIMIT   = 10'd2,
   parameter logic [9:0] RIGHT_LIMIT  = 10'd637,
   parameter logic [7:0] SERVE_FRAMES = 8'd60,
   parameter logic [3:0] WIN_SCORE    = 4'd9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       pause,
   input  logic [9:0] ball_x,
   output logic       ball_step,
   output logic       ball_restart,
   output logic       serve_dir,
   output logic [3:0] score_left,
   output logic [3:0] score_right,
   output logic [2:0] state,
   output logic       game_over
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SERVE     = 3'd1,
      PLAY      = 3'd2,
      SCORED    = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       start_q;
   logic       armed_q, armed_d;
   logic [7:0] serve_cnt_q, serve_cnt_d;
   logic       point_right_q, point_right_d;
   logic       ball_step_q, ball_step_d;
   logic       ball_restart_q, ball_restart_d;
   logic       serve_dir_q, serve_dir_d;
   logic [3:0] score_left_q, score_left_d;
   logic [3:0] score_right_q, score_right_d;
   logic       game_over_q, game_over_d;
   logic       start_rise;
   logic [3:0] next_left, next_right;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // armed_q blocks a start when the button is already held as reset releases;
   // it only arms once the button has been seen low.
   assign start_rise = start_btn & ~start_q & armed_q;
   assign next_left  = sat_inc(score_left_q);
   assign next_right = sat_inc(score_right_q);

   always_comb begin
      state_d        = state_q;
      armed_d        = armed_q | ~start_btn;
      serve_cnt_d    = serve_cnt_q;
      point_right_d  = point_right_q;
      ball_step_d    = 1'b0;
      ball_restart_d = 1'b0;
      serve_dir_d    = serve_dir_q;
      score_left_d   = score_left_q;
      score_right_d  = score_right_q;
      unique case (state_q)
         IDLE, GAME_OVER: begin
            if (start_rise) begin
               state_d        = SERVE;
               score_left_d   = '0;
               score_right_d  = '0;
               ball_restart_d = 1'b1;
               serve_dir_d    = 1'b1;
               serve_cnt_d    = '0;
            end
         end
         SERVE: begin
            if (frame_tick) begin
               if (serve_cnt_q == SERVE_FRAMES - 8'd1) begin
                  state_d     = PLAY;
                  serve_cnt_d = '0;
               end else begin
                  serve_cnt_d = serve_cnt_q + 8'd1;
               end
            end
         end
         PLAY: begin
            if (ball_x <= LEFT_LIMIT) begin
               point_right_d = 1'b1;
               state_d       = SCORED;
            end else if (ball_x >= RIGHT_LIMIT) begin
               point_right_d = 1'b0;
               state_d       = SCORED;
            end else begin
               ball_step_d = frame_tick & ~pause;
            end
         end
         SCORED: begin
            serve_cnt_d = '0;
            if (point_right_q) begin
               score_right_d = next_right;
               if (next_right == WIN_SCORE) begin
                  state_d = GAME_OVER;
               end else begin
                  state_d        = SERVE;
                  ball_restart_d = 1'b1;
                  serve_dir_d    = 1'b0;
               end
            end else begin
               score_left_d = next_left;
               if (next_left == WIN_SCORE) begin
                  state_d = GAME_OVER;
               end else begin
                  state_d        = SERVE;
                  ball_restart_d = 1'b1;
                  serve_dir_d    = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      game_over_d = (state_d == GAME_OVER);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         start_q        <= 1'b0;
         armed_q        <= 1'b0;
         serve_cnt_q    <= '0;
         point_right_q  <= 1'b0;
         ball_step_q    <= 1'b0;
         ball_restart_q <= 1'b0;
         serve_dir_q    <= 1'b1;
         score_left_q   <= '0;
         score_right_q  <= '0;
         game_over_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         start_q        <= start_btn;
         armed_q        <= armed_d;
         serve_cnt_q    <= serve_cnt_d;
         point_right_q  <= point_right_d;
         ball_step_q    <= ball_step_d;
         ball_restart_q <= ball_restart_d;
         serve_dir_q    <= serve_dir_d;
         score_left_q   <= score_left_d;
         score_right_q  <= score_right_d;
         game_over_q    <= game_over_d;
      end
   end

   assign ball_step    = ball_step_q;
   assign ball_restart = ball_restart_q;
   assign serve_dir    = serve_dir_q;
   assign score_left   = score_left_q;
   assign score_right  = score_right_q;
   assign state        = state_q;
   assign game_over    = game_over_q;

endmodule
